// File: rtl/simon_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// simon_block_sequencer_pkg : shared types and defaults for the Simon sequencer
// Revision : 1.0
// ============================================================================
package simon_block_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam int ERR_START   = 0;
   localparam int ERR_TIMEOUT = 1;

   localparam int DEF_KEY_BYTES = 8;
   localparam int DEF_BLK_BYTES = 4;
   localparam int DEF_TIMEOUT   = 256;

endpackage
`default_nettype wire

// File: rtl/simon_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// simon_block_sequencer_if : host write/read ports and cipher-core link
// Revision : 1.0
// ============================================================================
interface simon_block_sequencer_if
   import simon_block_sequencer_pkg::*;
#(
   parameter int KEY_BYTES = DEF_KEY_BYTES,
   parameter int BLK_BYTES = DEF_BLK_BYTES
);
   logic                   wr_valid;
   logic                   wr_is_key;
   logic [7:0]             wr_byte;
   logic                   wr_ready;
   logic                   start;
   logic                   busy;
   logic [7:0]             rd_byte;
   logic                   rd_valid;
   logic                   rd_ready;
   logic [1:0]             err;
   logic                   cip_rst;
   logic                   cip_en;
   logic [8*KEY_BYTES-1:0] cip_key;
   logic [8*BLK_BYTES-1:0] cip_pt;
   logic [8*BLK_BYTES-1:0] cip_ct;
   logic                   cip_done;

   modport slave (
      input  wr_valid, wr_is_key, wr_byte, start, rd_ready, cip_ct, cip_done,
      output wr_ready, busy, rd_byte, rd_valid, err, cip_rst, cip_en, cip_key, cip_pt
   );

   modport master (
      output wr_valid, wr_is_key, wr_byte, start, rd_ready, cip_ct, cip_done,
      input  wr_ready, busy, rd_byte, rd_valid, err, cip_rst, cip_en, cip_key, cip_pt
   );

endinterface
`default_nettype wire

// File: rtl/simon_block_sequencer_byte_shift_loader.sv
`default_nettype none
// ============================================================================
// simon_block_sequencer_byte_shift_loader : N-byte right-shift register with
// saturating byte count. Revision : 1.0
// ============================================================================
module simon_block_sequencer_byte_shift_loader #(
   parameter int N_BYTES = 4
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 clr_cnt_i,
   input  wire logic                 wr_i,
   input  wire logic [7:0]           byte_i,
   output      logic [8*N_BYTES-1:0] data_o,
   output      logic                 full_o
);
   localparam int CNT_W = $clog2(N_BYTES + 1);
   localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(N_BYTES);

   logic [8*N_BYTES-1:0] data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Data keeps shifting past saturation so the last N bytes are retained.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (wr_i) begin
         data_d = {byte_i, data_q[8*N_BYTES-1:8]};
      end
      if (clr_cnt_i) begin
         cnt_d = '0;
      end else if (wr_i && (cnt_q != C_CNT_FULL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_o = data_q;
   assign full_o = (cnt_q == C_CNT_FULL);

endmodule
`default_nettype wire

// File: rtl/simon_block_sequencer.sv
`default_nettype none
// ============================================================================
// simon_block_sequencer : byte-serial loader, run control with watchdog and
// ciphertext streamer for the Simon-32/64 core. Revision : 1.0
// ============================================================================
module simon_block_sequencer
   import simon_block_sequencer_pkg::*;
#(
   parameter int KEY_BYTES = DEF_KEY_BYTES,
   parameter int BLK_BYTES = DEF_BLK_BYTES,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input wire logic               clk,
   input wire logic               rst_n,
   input wire logic               clr,
   simon_block_sequencer_if.slave bus
);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int IDX_W = $clog2(BLK_BYTES);
   localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(BLK_BYTES - 1);

   state_e                 state_q, state_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [1:0]             err_q, err_d;
   logic [8*BLK_BYTES-1:0] ct_q, ct_d;
   logic [8*BLK_BYTES-1:0] w_ct_shift;
   logic                   w_wr_fire;
   logic                   w_pt_done;
   logic                   w_key_full;
   logic                   w_pt_full;

   assign w_wr_fire  = bus.wr_valid && (state_q == ST_IDLE) && !clr;
   assign w_ct_shift = ct_q >> {idx_q, 3'b000};

   simon_block_sequencer_byte_shift_loader #(.N_BYTES(KEY_BYTES)) u_key (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_cnt_i (clr),
      .wr_i      (w_wr_fire && bus.wr_is_key),
      .byte_i    (bus.wr_byte),
      .data_o    (bus.cip_key),
      .full_o    (w_key_full)
   );

   simon_block_sequencer_byte_shift_loader #(.N_BYTES(BLK_BYTES)) u_pt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_cnt_i (clr || w_pt_done),
      .wr_i      (w_wr_fire && !bus.wr_is_key),
      .byte_i    (bus.wr_byte),
      .data_o    (bus.cip_pt),
      .full_o    (w_pt_full)
   );

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      idx_d     = idx_q;
      err_d     = err_q;
      ct_d      = ct_q;
      w_pt_done = 1'b0;

      if (clr) begin
         state_d = ST_IDLE;
         wd_d    = '0;
         idx_d   = '0;
         err_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // Counts are registered, so a write in the same cycle is not seen.
               if (bus.start) begin
                  if (w_key_full && w_pt_full) begin
                     state_d = ST_RUN;
                     wd_d    = '0;
                  end else begin
                     err_d[ERR_START] = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.cip_done) begin
                  ct_d    = bus.cip_ct;
                  state_d = ST_OUT;
                  wd_d    = '0;
               end else if (wd_q == C_WD_LAST) begin
                  err_d[ERR_TIMEOUT] = 1'b1;
                  state_d   = ST_IDLE;
                  wd_d      = '0;
                  w_pt_done = 1'b1;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
            ST_OUT: begin
               if (bus.rd_ready) begin
                  if (idx_q == C_IDX_LAST) begin
                     idx_d     = '0;
                     w_pt_done = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wd_q    <= '0;
         idx_q   <= '0;
         err_q   <= '0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         ct_q    <= ct_d;
      end
   end

   // Cipher is held in reset outside RUN so a stale done is never sampled.
   always_comb begin
      bus.wr_ready = (state_q == ST_IDLE);
      bus.busy     = (state_q != ST_IDLE);
      bus.rd_valid = (state_q == ST_OUT);
      bus.rd_byte  = (state_q == ST_OUT) ? w_ct_shift[7:0] : 8'h00;
      bus.err      = err_q;
      bus.cip_rst  = (state_q != ST_RUN);
      bus.cip_en   = (state_q == ST_RUN);
   end

endmodule
`default_nettype wire

// File: tb/tb_simon_block_sequencer.sv
`default_nettype none
// ============================================================================
// tb_simon_block_sequencer : directed bench with a cipher stub whose done
// latency is programmable. Revision : 1.0
// ============================================================================
module tb_simon_block_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   checks = 0;
   int   errors = 0;
   int   delay  = 0;
   int   cnt    = 0;
   int   n;

   simon_block_sequencer_if #(.KEY_BYTES(8), .BLK_BYTES(4)) bus ();

   simon_block_sequencer #(.KEY_BYTES(8), .BLK_BYTES(4), .TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Stub: done is high on RUN cycle number 'delay' (1-based); 0 means never.
   always @(posedge clk) cnt <= bus.cip_rst ? 0 : cnt + 1;
   assign bus.cip_done = !bus.cip_rst && (delay != 0) && (cnt == delay - 1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic k, input logic [7:0] b);
      bus.wr_valid  = 1'b1;
      bus.wr_is_key = k;
      bus.wr_byte   = b;
      tick();
      bus.wr_valid  = 1'b0;
   endtask

   task automatic load(input logic [7:0] kb, input logic [7:0] pb, input int npt);
      for (int i = 0; i < 8; i++) wr(1'b1, kb + 8'(i));
      for (int i = 0; i < npt; i++) wr(1'b0, pb + 8'(i));
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // Counts cycles with cip_rst low, bounded.
   task automatic count_run(output int cycles);
      cycles = 0;
      while (bus.cip_rst == 1'b0 && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   task automatic read_ct(input logic [31:0] exp, input int stall_idx);
      logic [31:0] e;
      e = exp;
      for (int i = 0; i < 4; i++) begin
         check("rd_valid", 64'(bus.rd_valid), 64'd1);
         check("rd_byte", 64'(bus.rd_byte), 64'(e[8*i +: 8]));
         if (i == stall_idx) begin
            bus.rd_ready = 1'b0;
            repeat (3) begin
               tick();
               check("rd_byte_held", 64'(bus.rd_byte), 64'(e[8*i +: 8]));
            end
         end
         bus.rd_ready = 1'b1;
         tick();
      end
      bus.rd_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_is_key = 1'b0;
      bus.wr_byte   = 8'h00;
      bus.start     = 1'b0;
      bus.rd_ready  = 1'b0;
      bus.cip_ct    = 32'h0;
      #12;
      check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("rst_rd_byte", 64'(bus.rd_byte), 64'd0);
      check("rst_cip_rst", 64'(bus.cip_rst), 64'd1);
      check("rst_cip_en", 64'(bus.cip_en), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_key", bus.cip_key, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Basic encrypt
      load(8'h00, 8'h10, 4);
      check("key", bus.cip_key, 64'h0706050403020100);
      check("pt", 64'(bus.cip_pt), 64'h13121110);
      delay = 5;
      bus.cip_ct = 32'hDEADBEEF;
      pulse_start();
      check("run_busy", 64'(bus.busy), 64'd1);
      check("run_cip_rst", 64'(bus.cip_rst), 64'd0);
      check("run_cip_en", 64'(bus.cip_en), 64'd1);
      check("run_wr_ready", 64'(bus.wr_ready), 64'd0);
      n = 0;
      while (!bus.rd_valid && n < 50) begin n++; tick(); end
      check("done_latency", 64'(n), 64'd5);
      read_ct(32'hDEADBEEF, -1);
      check("post_busy", 64'(bus.busy), 64'd0);
      check("post_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("post_err", 64'(bus.err), 64'd0);

      // Key reuse with backpressure on byte 1
      for (int i = 0; i < 4; i++) wr(1'b0, 8'h20 + 8'(i));
      check("pt2", 64'(bus.cip_pt), 64'h23222120);
      delay = 3;
      bus.cip_ct = 32'h11223344;
      pulse_start();
      check("reuse_busy", 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.rd_valid && n < 50) begin n++; tick(); end
      check("done_latency2", 64'(n), 64'd3);
      read_ct(32'h11223344, 1);
      check("reuse_err", 64'(bus.err), 64'd0);

      // Rejected start: 3 pt bytes only
      for (int i = 0; i < 3; i++) wr(1'b0, 8'h30 + 8'(i));
      pulse_start();
      check("rej_err", 64'(bus.err), 64'd1);
      check("rej_busy", 64'(bus.busy), 64'd0);
      check("rej_cip_rst", 64'(bus.cip_rst), 64'd1);
      check("rej_wr_ready", 64'(bus.wr_ready), 64'd1);

      // Last pt write coincident with start
      do_clr();
      check("clr_err", 64'(bus.err), 64'd0);
      load(8'h40, 8'h50, 3);
      bus.start = 1'b1;
      wr(1'b0, 8'h53);
      bus.start = 1'b0;
      check("simul_err", 64'(bus.err), 64'd1);
      check("simul_busy", 64'(bus.busy), 64'd0);
      delay = 0;
      pulse_start();
      check("simul_next_busy", 64'(bus.busy), 64'd1);
      tick();
      tick();
      do_clr();
      check("clr_run_busy", 64'(bus.busy), 64'd0);
      check("clr_run_cip_rst", 64'(bus.cip_rst), 64'd1);
      check("clr_run_err", 64'(bus.err), 64'd0);
      pulse_start();
      check("clr_start_err", 64'(bus.err), 64'd1);

      // Watchdog timeout
      do_clr();
      load(8'h60, 8'h70, 4);
      delay = 0;
      pulse_start();
      count_run(n);
      check("wd_cycles", 64'(n), 64'd16);
      check("wd_err", 64'(bus.err), 64'd2);
      check("wd_busy", 64'(bus.busy), 64'd0);
      pulse_start();
      check("wd_pt_cleared", 64'(bus.err), 64'd3);

      // Done on the timeout cycle, then async reset mid-OUT
      do_clr();
      load(8'h80, 8'h90, 4);
      delay = 16;
      bus.cip_ct = 32'hCAFEF00D;
      pulse_start();
      count_run(n);
      check("edge_cycles", 64'(n), 64'd16);
      check("edge_rd_valid", 64'(bus.rd_valid), 64'd1);
      check("edge_err", 64'(bus.err), 64'd0);
      check("edge_b0", 64'(bus.rd_byte), 64'h0D);
      bus.rd_ready = 1'b1;
      tick();
      check("edge_b1", 64'(bus.rd_byte), 64'hF0);
      tick();
      bus.rd_ready = 1'b0;
      check("edge_b2", 64'(bus.rd_byte), 64'hFE);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("arst_cip_rst", 64'(bus.cip_rst), 64'd1);
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_rd_byte", 64'(bus.rd_byte), 64'd0);
      check("arst_key", bus.cip_key, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      pulse_start();
      check("arst_start_err", 64'(bus.err), 64'd1);
      check("arst_start_busy", 64'(bus.busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
